// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: opcode/funct constants, control codes and pipeline bundle types
package pipelined_control_unit_pkg;
  localparam logic [5:0] OP_R = 6'b000000, OP_REGIMM = 6'b000001, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [2:0] ALUOP_R = 3'd0, ALUOP_ADD = 3'd1, ALUOP_AND = 3'd2, ALUOP_OR = 3'd3;
  localparam logic [2:0] ALUOP_XOR = 3'd4, ALUOP_SLT = 3'd5, ALUOP_CMP = 3'd6;
  localparam logic [2:0] BRCOND_NONE = 3'd0, BRCOND_BEQ = 3'd1, BRCOND_BNE = 3'd2, BRCOND_BLEZ = 3'd3;
  localparam logic [2:0] BRCOND_BGTZ = 3'd4, BRCOND_BLTZ = 3'd5, BRCOND_BGEZ = 3'd6;
  localparam logic [1:0] MEMSZ_WORD = 2'd0, MEMSZ_HALF = 2'd1, MEMSZ_BYTE = 2'd2;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic [2:0] alu_op;
    logic [2:0] br_cond;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] mem_size;
    logic [4:0] dest;
  } ctrl_t;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] mem_size;
    logic [4:0] dest;
  } mem_ctrl_t;
  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] dest;
  } wb_ctrl_t;
endpackage

// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: IF/ID inputs, hazard controls and per-stage control bundle
interface pipelined_control_unit_if #(parameter int ALUOP_W = 3, parameter int CNT_W = 8);
  logic [31:0] instruction;
  logic id_valid, flush, stall, pc_write, if_id_write;
  logic ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_jump_reg, ex_link;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [2:0] ex_br_cond;
  logic ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [1:0] ex_mem_size;
  logic [4:0] ex_dest_reg;
  logic mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [1:0] mem_mem_size;
  logic [4:0] mem_dest_reg;
  logic wb_mem_to_reg, wb_reg_write;
  logic [4:0] wb_dest_reg;
  logic debug;
  logic [CNT_W-1:0] illegal_count;
  modport master (
    output instruction, id_valid, flush,
    input stall, pc_write, if_id_write, ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_jump_reg,
    ex_link, ex_alu_op, ex_br_cond, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
    ex_mem_size, ex_dest_reg, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
    mem_mem_size, mem_dest_reg, wb_mem_to_reg, wb_reg_write, wb_dest_reg, debug, illegal_count
  );
  modport slave (
    input instruction, id_valid, flush,
    output stall, pc_write, if_id_write, ex_reg_dst, ex_alu_src, ex_branch, ex_jump, ex_jump_reg,
    ex_link, ex_alu_op, ex_br_cond, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
    ex_mem_size, ex_dest_reg, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
    mem_mem_size, mem_dest_reg, wb_mem_to_reg, wb_reg_write, wb_dest_reg, debug, illegal_count
  );
endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// pipelined_control_unit_decoder: combinational MIPS main-control decode into a control bundle
module pipelined_control_unit_decoder import pipelined_control_unit_pkg::*; #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic [5:0] i_op,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_uses_rs,
  output logic       o_uses_rt
);
  always_comb begin
    o_ctrl = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_R: begin o_ctrl.reg_dst = 1'b1; o_ctrl.jump_reg = i_funct == FN_JR; o_ctrl.reg_write = i_funct != FN_JR; end
      OP_ADDI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALUOP_ADD; end
      OP_ANDI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALUOP_AND; end
      OP_ORI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALUOP_OR; end
      OP_XORI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALUOP_XOR; end
      OP_SLTI: begin o_ctrl.alu_src = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALUOP_SLT; end
      OP_LW, OP_LH, OP_LB: begin
        o_ctrl.alu_src = 1'b1; o_ctrl.alu_op = ALUOP_ADD; o_ctrl.mem_read = 1'b1; o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_size = i_op == OP_LW ? MEMSZ_WORD : i_op == OP_LH ? MEMSZ_HALF : MEMSZ_BYTE;
      end
      OP_SW, OP_SH, OP_SB: begin
        o_ctrl.alu_src = 1'b1; o_ctrl.alu_op = ALUOP_ADD; o_ctrl.mem_write = 1'b1;
        o_ctrl.mem_size = i_op == OP_SW ? MEMSZ_WORD : i_op == OP_SH ? MEMSZ_HALF : MEMSZ_BYTE;
      end
      OP_REGIMM: begin o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALUOP_CMP; o_ctrl.br_cond = i_rt[0] ? BRCOND_BGEZ : BRCOND_BLTZ; end
      OP_BEQ: begin o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALUOP_CMP; o_ctrl.br_cond = BRCOND_BEQ; end
      OP_BNE: begin o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALUOP_CMP; o_ctrl.br_cond = BRCOND_BNE; end
      OP_BLEZ: begin o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALUOP_CMP; o_ctrl.br_cond = BRCOND_BLEZ; end
      OP_BGTZ: begin o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALUOP_CMP; o_ctrl.br_cond = BRCOND_BGTZ; end
      OP_J: o_ctrl.jump = 1'b1;
      OP_JAL: begin o_ctrl.jump = 1'b1; o_ctrl.link = 1'b1; o_ctrl.reg_write = 1'b1; end
      default: o_illegal = 1'b1;
    endcase
    // MemtoReg=1 picks the ALU result, so only loads route memory data back
    o_ctrl.mem_to_reg = o_ctrl.reg_write & ~o_ctrl.mem_read;
    o_ctrl.dest = o_ctrl.reg_dst ? i_rd : o_ctrl.link ? LINK_REG : i_rt;
  end
  assign o_uses_rs = i_op != OP_J && i_op != OP_JAL;
  assign o_uses_rt = i_op == OP_R || i_op == OP_SW || i_op == OP_SH || i_op == OP_SB || i_op == OP_BEQ || i_op == OP_BNE;
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall,
// flush bubbles and saturating illegal-opcode counter.
module pipelined_control_unit import pipelined_control_unit_pkg::*; #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W = 8,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input logic i_clk,
  input logic i_rst,
  pipelined_control_unit_if.slave io_bus
);
  ctrl_t w_dec, r_ex;
  mem_ctrl_t r_mem;
  wb_ctrl_t r_wb;
  logic w_illegal, w_uses_rs, w_uses_rt, w_hit, w_stall, w_count, w_bubble, r_debug;
  logic [4:0] w_rs, w_rt;
  logic [CNT_W-1:0] r_cnt;
  assign w_rs = io_bus.instruction[25:21];
  assign w_rt = io_bus.instruction[20:16];
  pipelined_control_unit_decoder #(.LINK_REG(LINK_REG)) u_dec (
    .i_op(io_bus.instruction[31:26]), .i_rt(w_rt), .i_rd(io_bus.instruction[15:11]),
    .i_funct(io_bus.instruction[5:0]), .o_ctrl(w_dec), .o_illegal(w_illegal),
    .o_uses_rs(w_uses_rs), .o_uses_rt(w_uses_rt)
  );
  assign w_hit = (w_uses_rs && r_ex.dest == w_rs) || (w_uses_rt && r_ex.dest == w_rt);
  assign w_stall = r_ex.mem_read && r_ex.reg_write && r_ex.dest != 5'd0 && io_bus.id_valid && !io_bus.flush && w_hit;
  assign w_count = io_bus.id_valid && !w_stall && !io_bus.flush && w_illegal;
  assign w_bubble = io_bus.flush || w_stall || !io_bus.id_valid || w_illegal;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex <= '0;
      r_mem <= '0;
      r_wb <= '0;
      r_debug <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_ex <= w_bubble ? '0 : w_dec;
      r_mem <= {r_ex.mem_read, r_ex.mem_write, r_ex.mem_to_reg, r_ex.reg_write, r_ex.mem_size, r_ex.dest};
      r_wb <= {r_mem.mem_to_reg, r_mem.reg_write, r_mem.dest};
      r_debug <= w_count;
      if (w_count && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign io_bus.stall = w_stall;
  assign io_bus.pc_write = ~w_stall;
  assign io_bus.if_id_write = ~w_stall;
  assign io_bus.ex_reg_dst = r_ex.reg_dst;
  assign io_bus.ex_alu_src = r_ex.alu_src;
  assign io_bus.ex_branch = r_ex.branch;
  assign io_bus.ex_jump = r_ex.jump;
  assign io_bus.ex_jump_reg = r_ex.jump_reg;
  assign io_bus.ex_link = r_ex.link;
  assign io_bus.ex_alu_op = ALUOP_W'(r_ex.alu_op);
  assign io_bus.ex_br_cond = r_ex.br_cond;
  assign io_bus.ex_mem_read = r_ex.mem_read;
  assign io_bus.ex_mem_write = r_ex.mem_write;
  assign io_bus.ex_mem_to_reg = r_ex.mem_to_reg;
  assign io_bus.ex_reg_write = r_ex.reg_write;
  assign io_bus.ex_mem_size = r_ex.mem_size;
  assign io_bus.ex_dest_reg = r_ex.dest;
  assign io_bus.mem_mem_read = r_mem.mem_read;
  assign io_bus.mem_mem_write = r_mem.mem_write;
  assign io_bus.mem_mem_to_reg = r_mem.mem_to_reg;
  assign io_bus.mem_reg_write = r_mem.reg_write;
  assign io_bus.mem_mem_size = r_mem.mem_size;
  assign io_bus.mem_dest_reg = r_mem.dest;
  assign io_bus.wb_mem_to_reg = r_wb.mem_to_reg;
  assign io_bus.wb_reg_write = r_wb.reg_write;
  assign io_bus.wb_dest_reg = r_wb.dest;
  assign io_bus.debug = r_debug;
  assign io_bus.illegal_count = r_cnt;
endmodule
